// File: rtl/vert_batch_sequencer.sv
// Walks a batch of vertices through one projector: fetch, load, start, await done, emit result.
// Optional projector watchdog is compiled in with `define VERT_BATCH_SEQ_WDOG_EN.
module vert_batch_sequencer #(
  parameter int unsigned N           = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_go,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [ADDR_W:0]     i_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_vmem_rd_en,
  output logic [ADDR_W-1:0]   o_vmem_addr,
  input  logic [4*N-1:0]      i_vmem_rdata,
  output logic                o_proj_start,
  output logic [4*N-1:0]      o_proj_vertex,
  input  logic                i_proj_done,
  input  logic [3*N-1:0]      i_proj_vector,
  output logic                o_res_valid,
  output logic [3*N-1:0]      o_res_data,
  output logic [ADDR_W-1:0]   o_res_index,
  input  logic                i_res_ready
);

  localparam int unsigned VW = 4 * N;
  localparam int unsigned RW = 3 * N;
  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_EMIT, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                start_q, start_d;
  logic [VW-1:0]       vertex_q, vertex_d;
  logic                valid_q, valid_d;
  logic [RW-1:0]       data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;

`ifdef VERT_BATCH_SEQ_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                wd_expired;
  assign wd_expired = (wd_q == WD_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
`endif

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    start_d  = 1'b0;
    vertex_d = vertex_q;
    valid_d  = valid_q;
    data_d   = data_q;
    index_d  = index_q;
`ifdef VERT_BATCH_SEQ_WDOG_EN
    wd_d     = wd_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_go) begin
          rem_d = i_count;
          ptr_d = i_base_addr;
          idx_d = '0;
          err_d = 1'b0;
          if (i_count == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FETCH;
            rd_en_d = 1'b1;
            addr_d  = i_base_addr;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        vertex_d = i_vmem_rdata;
        start_d  = 1'b1;
        state_d  = S_START;
      end
      S_START: begin
        state_d = S_WAIT_LO;
`ifdef VERT_BATCH_SEQ_WDOG_EN
        wd_d    = '0;
`endif
      end
      // A done level still high from the previous vertex must drop first.
      S_WAIT_LO: begin
        if (!i_proj_done) begin
          state_d = S_WAIT_HI;
`ifdef VERT_BATCH_SEQ_WDOG_EN
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FIN;
`endif
        end
`ifdef VERT_BATCH_SEQ_WDOG_EN
        wd_d = wd_q + WD_W'(1);
`endif
      end
      S_WAIT_HI: begin
        if (i_proj_done) begin
          data_d  = i_proj_vector;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = S_EMIT;
`ifdef VERT_BATCH_SEQ_WDOG_EN
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_FIN;
`endif
        end
`ifdef VERT_BATCH_SEQ_WDOG_EN
        wd_d = wd_q + WD_W'(1);
`endif
      end
      S_EMIT: begin
        if (valid_q && i_res_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_q + ADDR_W'(1);
          idx_d   = idx_q + ADDR_W'(1);
          rem_d   = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FETCH;
            rd_en_d = 1'b1;
            addr_d  = ptr_q + ADDR_W'(1);
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      start_q  <= 1'b0;
      vertex_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      index_q  <= '0;
`ifdef VERT_BATCH_SEQ_WDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      vertex_q <= vertex_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      index_q  <= index_d;
`ifdef VERT_BATCH_SEQ_WDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_vmem_rd_en  = rd_en_q;
  assign o_vmem_addr   = addr_q;
  assign o_proj_start  = start_q;
  assign o_proj_vertex = vertex_q;
  assign o_res_valid   = valid_q;
  assign o_res_data    = data_q;
  assign o_res_index   = index_q;

endmodule

// File: tb/tb_vert_batch_sequencer.sv
// Randomized bench for vert_batch_sequencer: vertex memory, projector model and result scoreboard.
module tb_vert_batch_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned WD = 40;
`ifdef VERT_BATCH_SEQ_WDOG_EN
  localparam int LAT0 = 30;
`else
  localparam int LAT0 = 70;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_go = 1'b0;
  logic [AW-1:0]   i_base_addr = '0;
  logic [AW:0]     i_count = '0;
  logic            o_busy, o_done, o_err, o_vmem_rd_en, o_proj_start, o_res_valid;
  logic [AW-1:0]   o_vmem_addr, o_res_index;
  logic [4*N-1:0]  vmem_rdata = '0;
  logic [4*N-1:0]  o_proj_vertex;
  logic            proj_done = 1'b0;
  logic [3*N-1:0]  proj_vec = '0;
  logic [3*N-1:0]  o_res_data;
  logic            i_res_ready = 1'b1;

  vert_batch_sequencer #(.N(N), .ADDR_W(AW), .WDOG_CYCLES(WD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(i_go), .i_base_addr(i_base_addr), .i_count(i_count),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_vmem_rd_en(o_vmem_rd_en), .o_vmem_addr(o_vmem_addr), .i_vmem_rdata(vmem_rdata),
    .o_proj_start(o_proj_start), .o_proj_vertex(o_proj_vertex),
    .i_proj_done(proj_done), .i_proj_vector(proj_vec),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_index(o_res_index),
    .i_res_ready(i_res_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*N-1:0] proj_fn(input logic [4*N-1:0] v);
    logic [N-1:0] x, y, z, w;
    {x, y, z, w} = v;
    return {x + y, y ^ z, z - w};
  endfunction

  logic [4*N-1:0] mem [256];

  always @(posedge clk) if (o_vmem_rd_en) vmem_rdata <= mem[o_vmem_addr];

  // Projector model: done drops drop_dly cycles after start, rises proj_lat cycles after start.
  int  proj_lat = LAT0;
  int  drop_dly = 0;
  bit  proj_never = 1'b0;
  int  pcnt = 0;
  bit  pbusy = 1'b0;
  logic [4*N-1:0] pvtx = '0;

  always @(posedge clk) begin
    if (o_proj_start) begin
      pbusy = 1'b1;
      pcnt  = 0;
      pvtx  = o_proj_vertex;
    end else if (pbusy) begin
      pcnt++;
    end
    if (pbusy) begin
      if (pcnt == drop_dly) proj_done <= 1'b0;
      if (!proj_never && pcnt == proj_lat) begin
        proj_done <= 1'b1;
        proj_vec  <= proj_fn(pvtx);
        pbusy = 1'b0;
      end
    end
  end

  // Ready policy: 0 tied high, 1 random, 2 stall vertex index 1 for 20 cycles.
  int rdy_mode  = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin i_res_ready = 1'b1; stall_cnt = 0; end
      1: begin i_res_ready = ($urandom_range(0, 3) != 0); stall_cnt = 0; end
      default: begin
        if (o_res_valid && o_res_index == AW'(1) && stall_cnt < 20) begin
          i_res_ready = 1'b0;
          stall_cnt++;
        end else begin
          i_res_ready = 1'b1;
        end
      end
    endcase
  end

  // Scoreboard expectations built from the batch definition.
  logic [AW-1:0]  exp_addr [$];
  logic [3*N-1:0] exp_data [$];
  logic [AW-1:0]  exp_idx  [$];

  int rd_cnt = 0, st_cnt = 0, rs_cnt = 0, dn_cnt = 0;
  logic [AW-1:0]  last_rd = '0;
  bit             held = 1'b0;
  logic [3*N-1:0] held_data = '0;
  logic [AW-1:0]  held_idx = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (o_vmem_rd_en) begin
        rd_cnt++;
        last_rd = o_vmem_addr;
        check("rd_during_valid", o_res_valid, 1'b0);
        if (exp_addr.size() == 0) check("rd_extra", 1'b1, 1'b0);
        else check("rd_addr", o_vmem_addr, exp_addr.pop_front());
      end
      if (o_proj_start) begin
        st_cnt++;
        check("proj_vertex", o_proj_vertex, mem[last_rd]);
      end
      if (o_res_valid) begin
        if (held) begin
          check("hold_data", o_res_data, held_data);
          check("hold_idx", o_res_index, held_idx);
        end
        if (i_res_ready) begin
          rs_cnt++;
          if (exp_data.size() == 0) check("res_extra", 1'b1, 1'b0);
          else begin
            check("res_data", o_res_data, exp_data.pop_front());
            check("res_idx", o_res_index, exp_idx.pop_front());
          end
        end
      end
      if (o_done) dn_cnt++;
      held      = o_res_valid && !i_res_ready;
      held_data = o_res_data;
      held_idx  = o_res_index;
    end
  end

  task automatic expect_batch(input logic [AW-1:0] base, input logic [AW:0] cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(proj_fn(mem[a]));
      exp_idx.push_back(AW'(i));
    end
  endtask

  task automatic run_batch(input logic [AW-1:0] base, input logic [AW:0] cnt, input bit noise);
    int rd0, st0, rs0, dn0, t;
    expect_batch(base, cnt);
    rd0 = rd_cnt; st0 = st_cnt; rs0 = rs_cnt; dn0 = dn_cnt;
    @(posedge clk); #1;
    i_go = 1'b1; i_base_addr = base; i_count = cnt;
    @(posedge clk); #1;
    i_go = 1'b0;
    t = 0;
    while (dn_cnt == dn0 && t < 20000) begin
      @(posedge clk); #1;
      t++;
      if (noise && o_busy) begin
        i_go        = 1'($urandom_range(0, 1));
        i_base_addr = AW'($urandom);
        i_count     = (AW + 1)'($urandom);
      end else begin
        i_go = 1'b0;
      end
    end
    i_go = 1'b0;
    check("batch_timeout", t < 20000, 1'b1);
    @(negedge clk);
    check("batch_reads", rd_cnt - rd0, cnt);
    check("batch_starts", st_cnt - st0, cnt);
    check("batch_results", rs_cnt - rs0, cnt);
    check("batch_done", dn_cnt - dn0, 1);
    check("batch_err", o_err, 1'b0);
    check("batch_busy", o_busy, 1'b0);
    check("batch_left", exp_addr.size() + exp_data.size(), 0);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (o_proj_start) seen = 1'b1;
    end
    check("start_seen", seen, 1'b1);
  endtask

  initial begin
    int rd0, st0, rs0, dn0;
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_outs", {o_done, o_err, o_vmem_rd_en, o_proj_start, o_res_valid}, '0);
    check("rst_vertex", o_proj_vertex, '0);
    check("rst_data", {o_res_data, o_res_index, o_vmem_addr}, '0);
    rst_n = 1'b1;

    rdy_mode = 0; proj_lat = LAT0; drop_dly = 0;
    run_batch(8'h10, 9'd3, 1'b0);

    // Empty batch: done two cycles after go, nothing else happens.
    rd0 = rd_cnt; st0 = st_cnt; rs0 = rs_cnt; dn0 = dn_cnt;
    @(posedge clk); #1;
    i_go = 1'b1; i_base_addr = 8'h33; i_count = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cnt0_done", o_done, k == 2);
      if (k == 1) i_go = 1'b0;
    end
    check("cnt0_reads", rd_cnt - rd0, 0);
    check("cnt0_starts", st_cnt - st0, 0);
    check("cnt0_results", rs_cnt - rs0, 0);
    check("cnt0_done_cnt", dn_cnt - dn0, 1);

    proj_lat = 5;
    run_batch(8'hFE, 9'd4, 1'b0);

    rdy_mode = 2;
    run_batch(8'h80, 9'd4, 1'b1);
    check("stall_len", stall_cnt, 20);

    // Done left high from the previous vertex and dropped late.
    rdy_mode = 0; proj_lat = 6; drop_dly = 2;
    run_batch(AW'($urandom), 9'd4, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rdy_mode = 1;
      proj_lat = $urandom_range(2, 20);
      drop_dly = $urandom_range(0, proj_lat - 1);
      run_batch(AW'($urandom), (AW + 1)'($urandom_range(1, 8)), r[0]);
    end

    rdy_mode = 0; proj_lat = 2; drop_dly = 1;
    run_batch(8'h40, 9'd256, 1'b0);

    // Asynchronous reset while waiting for the projector.
    proj_never = 1'b1; drop_dly = 0;
    expect_batch(8'h20, 9'd3);
    @(posedge clk); #1;
    i_go = 1'b1; i_base_addr = 8'h20; i_count = 9'd3;
    @(posedge clk); #1;
    i_go = 1'b0;
    wait_start(seen);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_outs", {o_done, o_err, o_vmem_rd_en, o_proj_start, o_res_valid}, '0);
    check("mid_rst_vertex", o_proj_vertex, '0);
    check("mid_rst_data", {o_res_data, o_res_index, o_vmem_addr}, '0);
    exp_addr.delete(); exp_data.delete(); exp_idx.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    proj_never = 1'b0; proj_lat = 4;
    run_batch(8'h21, 9'd2, 1'b0);

`ifdef VERT_BATCH_SEQ_WDOG_EN
    begin
      int n;
      proj_never = 1'b1; drop_dly = 0;
      exp_addr.push_back(8'h50);
      rd0 = rd_cnt; rs0 = rs_cnt;
      @(posedge clk); #1;
      i_go = 1'b1; i_base_addr = 8'h50; i_count = 9'd3;
      @(posedge clk); #1;
      i_go = 1'b0;
      wait_start(seen);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_done && n < 300);
      check("wdog_latency", n, 42);
      check("wdog_err", o_err, 1'b1);
      check("wdog_busy", o_busy, 1'b0);
      repeat (3) @(negedge clk);
      check("wdog_err_sticky", o_err, 1'b1);
      check("wdog_reads", rd_cnt - rd0, 1);
      check("wdog_results", rs_cnt - rs0, 0);
      proj_never = 1'b0; proj_lat = 3;
      run_batch(8'h60, 9'd1, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vert_batch_sequencer.md
Name: vert_batch_sequencer

Overview:
- Sequences a batch of vertices from the vertex buffer through one vert_projector instance, one vertex at a time.
- Fetches a vertex, holds it stable on the projector input and issues the projector start pulse. Waits for the projector's done level, then presents the projected vector on a valid/ready result port.
- Sits between the draw-command front end (go/base/count) and the rasterizer's vertex-result FIFO.

Parameters:
- N, 16, fixed-point word width per component; must match the projector's N.
- ADDR_W, 8, vertex buffer address width.
- WDOG_CYCLES, 255, projector wait limit per vertex; used only when the optional feature is compiled in.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_go  in  1  batch start; sampled only in IDLE.
- i_base_addr  in  ADDR_W  first vertex address; captured on accepted go.
- i_count  in  ADDR_W+1  number of vertices, 0..2^ADDR_W; captured on accepted go.
- o_busy  out  1  high from the cycle after go is accepted until the return to IDLE.
- o_done  out  1  one-cycle pulse at batch end.
- o_err  out  1  sticky watchdog error flag.
- o_vmem_rd_en  out  1  vertex buffer read strobe.
- o_vmem_addr  out  ADDR_W  read address.
- i_vmem_rdata  in  N*4  {x,y,z,w}; valid exactly 1 cycle after rd_en.
- o_proj_start  out  1  projector start pulse.
- o_proj_vertex  out  N*4  vertex held stable for the projector.
- i_proj_done  in  1  projector done level.
- i_proj_vector  in  N*3  {x,y,z} projected result.
- o_res_valid  out  1  result valid.
- o_res_data  out  N*3  projected vector.
- o_res_index  out  ADDR_W  vertex ordinal within the batch, starting at 0.
- i_res_ready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - All outputs and internal registers are 0, including o_proj_vertex, o_res_data and o_err.
- States: IDLE, FETCH, LOAD, START, WAIT_LO, WAIT_HI, EMIT, FIN.
- IDLE:
  - i_go=1: capture base and count, clear o_err, ptr:=base, idx:=0.
  - If count==0, go to FIN; otherwise go to FETCH.
- FETCH: o_vmem_rd_en=1 and o_vmem_addr=ptr for exactly one cycle, then LOAD.
- LOAD: o_proj_vertex<=i_vmem_rdata, then START. o_proj_vertex is unchanged in every other state.
- START: o_proj_start=1 for exactly one cycle, then WAIT_LO. o_proj_start is low in every other state, so the projector always sees a fresh rising edge.
- WAIT_LO:
  - Wait for i_proj_done==0, which confirms the projector accepted the start.
  - A stale done level from the previous vertex must never be taken as completion.
  - Then go to WAIT_HI.
- WAIT_HI: on i_proj_done==1, o_res_data<=i_proj_vector, o_res_index<=idx, o_res_valid<=1, then EMIT.
- EMIT:
  - Hold valid, data and index stable until the valid&&ready cycle.
  - In that cycle: valid<=0, ptr<=ptr+1 (wraps modulo 2^ADDR_W), idx<=idx+1.
  - If the remaining count reaches 0, go to FIN; otherwise go to FETCH.
- FIN: o_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Timing:
  - Per-vertex overhead excluding projector and downstream stall: FETCH+LOAD+START = 3 cycles, plus 1 cycle from done to valid.
  - Count==0: o_done pulses 2 cycles after go; no read and no start is issued.
- i_go while busy: ignored, with no effect on the captured base/count.
- i_count=2^ADDR_W: every address is visited once, wrapping past 2^ADDR_W-1 to 0.
- Reset mid-batch: immediate return to IDLE with outputs cleared.
  - An in-flight projector operation is abandoned.
  - The next batch's WAIT_LO step absorbs the projector's leftover done level.
- i_res_ready high in the same cycle valid rises: the handshake completes in that first EMIT cycle.

Optional Feature:
- Macro VERT_BATCH_SEQ_WDOG_EN.
- Defined:
  - A wait counter clears on entry to WAIT_LO and increments in WAIT_LO and WAIT_HI.
  - When the counter reaches WDOG_CYCLES while still waiting: o_err<=1, go to FIN, and the remaining vertices are skipped.
  - o_err holds until the next accepted go.
- Not defined:
  - No counter is built, o_err is tied to 0, and the block waits indefinitely for the projector.

Test Plan:
- Reset, then go with base=0x10 and count=3, projector model done after 70 cycles, ready tied 1 → reads at 0x10, 0x11, 0x12 in order; 3 results with index 0, 1, 2 carrying the model's vectors; one o_done pulse; o_err=0.
- Go with count=0 → o_done exactly 2 cycles after go; no rd_en, no proj_start, no res_valid.
- Base=0xFE, count=4 → addresses 0xFE, 0xFF, 0x00, 0x01; index 0..3.
- Ready held low 20 cycles on vertex 1 → valid, data and index stable throughout; next FETCH only after the handshake; extra go pulses during the batch ignored.
- Projector model that leaves done high from the previous vertex and drops it 2 cycles after start → no premature capture; each result taken only after the low-to-high transition.
- With VERT_BATCH_SEQ_WDOG_EN and WDOG_CYCLES=40, model never asserts done → o_err=1 and o_done pulse after 40 wait cycles; busy drops. Second case: async reset mid-WAIT_HI clears all outputs in the same cycle.
